// File: rtl/bram_be_client.sv
// Initiator-side controller for a single-port byte-enable block RAM: drives the
// RAM from a request channel and returns read data through a small response FIFO.
module bram_be_client #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [BE_WIDTH-1:0]   req_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [BE_WIDTH-1:0]   ram_be,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(RSP_DEPTH);

  // Handshake: a transfer happens on the rising edge where valid && ready; the
  // source holds payload stable while valid is high and ready is low, and
  // rsp_valid never drops before the response is taken.

  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];

  logic           fire, push, pop, credit_ok;
  logic [CNT_W:0] occ;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads take a credit from registered occupancy only, so rsp_ready never
  // reaches req_ready combinationally.
  always_comb begin
    occ       = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    credit_ok = (occ < DEPTH_OCC);
    req_ready = RST_N & (req_write | credit_ok);
    fire      = req_valid & req_ready;
    ram_addr  = req_addr;
    ram_di    = req_data;
    ram_be    = req_mask;
    ram_we    = fire & req_write;
    ram_re    = fire & ~req_write;
    rsp_valid = (count_q != '0);
    rsp_data  = mem_q[rd_ptr_q];
  end

  // RAM output is captured unconditionally the cycle after a read fire.
  always_comb begin
    inflight_d = ram_re;
    push       = inflight_q;
    pop        = rsp_valid & rsp_ready;
    wr_ptr_d   = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    for (int i = 0; i < RSP_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = ram_do;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bram_be_client.sv
// Directed bench for bram_be_client with a behavioural byte-enable RAM and an
// in-order response scoreboard.
module tb_bram_be_client;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int DEPTH = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [BW-1:0] req_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic          ram_we;
  logic          ram_re;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_do = '0;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ram [1024];

  bram_be_client #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RSP_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_re(ram_re),
    .ram_be(ram_be), .ram_do(ram_do)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // behavioural RAM: byte-enable write, registered read
  always @(posedge CLK) begin
    if (ram_we) begin
      for (int b = 0; b < BW; b++) begin
        if (ram_be[b]) ram[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
      end
    end
    if (ram_re) ram_do <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every consumed response must match the head of exp_q
  always @(negedge CLK) begin
    if (RST_N && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
      else chk("rsp_data", rsp_data, exp_q.pop_front());
    end
    if (RST_N && (32'(dut.count_q) + 32'(dut.inflight_q) > DEPTH))
      chk("occupancy", 32'(dut.count_q) + 32'(dut.inflight_q), DEPTH);
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] m);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_data = d; req_mask = m;
    @(negedge CLK);
    chk("wr_ready", {31'b0, req_ready}, 32'h1);
    chk("wr_we", {31'b0, ram_we}, 32'h1);
    chk("wr_be", {28'b0, ram_be}, {28'b0, m});
    step();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int n;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    n = 0;
    @(negedge CLK);
    while (!req_ready && n < 20) begin
      step();
      @(negedge CLK);
      n++;
    end
    chk("rd_ready", {31'b0, req_ready}, 32'h1);
    chk("rd_re", {31'b0, ram_re}, {31'b0, req_ready});
    step();
    req_valid = 1'b0;
    if (n < 20) exp_q.push_back(exp);
  endtask

  initial begin
    logic rdy;
    int fires;
    int n;
    logic [AW-1:0] a;

    // reset: outputs forced low even with a write presented
    #1 RST_N = 1'b0;
    req_valid = 1'b1; req_write = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'h0);
    chk("rst_ram_re", {31'b0, ram_re}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    req_valid = 1'b0; req_write = 1'b0;
    step(); step();
    RST_N = 1'b1;
    step();

    // write then read with 2-cycle latency
    wr(10'd5, 32'hDEADBEEF, 4'hF);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd5;
    @(negedge CLK);
    chk("t1_rd_ready", {31'b0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge CLK);
    chk("t1_lat_n1", {31'b0, rsp_valid}, 32'h0);
    step();
    @(negedge CLK);
    chk("t1_lat_n2", {31'b0, rsp_valid}, 32'h1);
    chk("t1_data", rsp_data, 32'hDEADBEEF);
    step();

    // partial byte-enable merge
    wr(10'd7, 32'h11223344, 4'hF);
    wr(10'd7, 32'hAABBCCDD, 4'h5);
    rd(10'd7, 32'h11BB33DD);
    repeat (3) step();

    // full-rate streaming of 16 reads
    for (int i = 0; i < 16; i++) wr(AW'(i), DW'(i), 4'hF);
    for (int i = 0; i < 18; i++) begin
      req_valid = (i < 16); req_write = 1'b0; req_addr = AW'(i);
      @(negedge CLK);
      if (i < 16) chk("t3_ready", {31'b0, req_ready}, 32'h1);
      chk("t3_stream", {31'b0, rsp_valid}, (i >= 2) ? 32'h1 : 32'h0);
      step();
      if (i < 16) exp_q.push_back(DW'(i));
    end
    req_valid = 1'b0;
    @(negedge CLK);
    chk("t3_done", {31'b0, rsp_valid}, 32'h0);
    chk("t3_q_empty", exp_q.size(), 32'h0);
    step();

    // backpressure: credits run out after DEPTH reads, writes still pass
    rsp_ready = 1'b0;
    fires = 0; a = '0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      rdy = req_ready;
      step();
      if (rdy) begin
        exp_q.push_back(DW'(a));
        fires++;
        a = a + 1'b1;
        req_addr = a;
      end
    end
    @(negedge CLK);
    chk("t4_fires", fires, DEPTH);
    chk("t4_blocked", {31'b0, req_ready}, 32'h0);
    chk("t4_head_valid", {31'b0, rsp_valid}, 32'h1);
    chk("t4_head_data", rsp_data, 32'h0);
    step();
    req_write = 1'b1; req_addr = 10'd40; req_data = 32'hCAFEF00D; req_mask = 4'hF;
    @(negedge CLK);
    chk("t4_wr_ready", {31'b0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0; req_write = 1'b0;
    @(negedge CLK);
    chk("t4_hold_data", rsp_data, 32'h0);
    step();
    rsp_ready = 1'b1;
    repeat (6) step();
    chk("t4_drained", exp_q.size(), 32'h0);
    rd(10'd40, 32'hCAFEF00D);
    repeat (3) step();

    // reset with a read in flight
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd5;
    @(negedge CLK);
    chk("t5_rd_ready", {31'b0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("t5_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("t5_inflight", {31'b0, dut.inflight_q}, 32'h0);
    step(); step();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t5_no_rsp", {31'b0, rsp_valid}, 32'h0);
      step();
    end
    chk("t5_count", 32'(dut.count_q), 32'h0);
    chk("t5_inflight_after", {31'b0, dut.inflight_q}, 32'h0);

    // zero-mask write leaves memory unchanged
    wr(10'd3, 32'h12345678, 4'hF);
    wr(10'd3, 32'hFFFFFFFF, 4'h0);
    rd(10'd3, 32'h12345678);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("final_drain", exp_q.size(), 32'h0);
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
